// File: rtl/game_state_ctrl_if.sv
// Bus between game_state_ctrl and its neighbours: keyboard/hit inputs, tick/screen/score outputs.
// Widths of Score and LivesLeft follow the COIN_TARGET and LIVES parameters of the instance.
interface game_state_ctrl_if #(
  parameter int COIN_TARGET = 10,
  parameter int LIVES       = 3
);
  localparam int SW_S = $clog2(COIN_TARGET + 1);
  localparam int SW_L = $clog2(LIVES + 1);

  logic [2:0]      SW;
  logic            EnterEn;
  logic            LoadDone;
  logic            CoinHit;
  logic            PoliceHit;
  logic            Pause;
  logic            SpeedTick;
  logic            DriveEn;
  logic [SW_S-1:0] Score;
  logic [SW_L-1:0] LivesLeft;
  logic            CrashFlash;
  logic            win_screen;
  logic            lose_screen;
  logic [2:0]      State;

  modport master (
    output SW, EnterEn, LoadDone, CoinHit, PoliceHit, Pause,
    input  SpeedTick, DriveEn, Score, LivesLeft, CrashFlash, win_screen, lose_screen, State
  );

  modport slave (
    input  SW, EnterEn, LoadDone, CoinHit, PoliceHit, Pause,
    output SpeedTick, DriveEn, Score, LivesLeft, CrashFlash, win_screen, lose_screen, State
  );
endinterface

// File: rtl/game_state_ctrl.sv
// Car-game flow controller: WAIT/LOAD/DRIVE/COIN/CRASH/WIN/LOSE FSM plus speed-tick divider on CLOCK_50.
// Optional pause state is built only when GAME_PAUSE_EN is defined.
//
// state | meaning
// WAIT  | idle, waiting for Enter
// LOAD  | draw logic paints initial scene
// DRIVE | car driving, hits evaluated
// COIN  | one-cycle score update
// CRASH | invincible recovery for RECOVER_T speed ticks
// WIN   | coin target reached, hold for Enter
// LOSE  | out of lives, hold for Enter
// PAUSE | driving frozen (GAME_PAUSE_EN only)
module game_state_ctrl #(
  parameter int COIN_TARGET = 10,
  parameter int LIVES       = 3,
  parameter int TICK_HALF   = 25_000_000,
  parameter int RECOVER_T   = 4
) (
  input  logic              CLOCK_50,
  input  logic              Reset,
  game_state_ctrl_if.slave  bus
);
  localparam int SW_S  = $clog2(COIN_TARGET + 1);
  localparam int SW_L  = $clog2(LIVES + 1);
  localparam int DIV_W = (TICK_HALF > 1) ? $clog2(TICK_HALF) : 1;
  localparam int REC_W = (RECOVER_T > 0) ? $clog2(RECOVER_T + 1) : 1;

  localparam logic [SW_S-1:0]  TARGET_V = SW_S'(COIN_TARGET);
  localparam logic [SW_S-1:0]  SC_ONE   = SW_S'(1);
  localparam logic [SW_L-1:0]  LIVES_V  = SW_L'(LIVES);
  localparam logic [SW_L-1:0]  LV_ONE   = SW_L'(1);
  localparam logic [REC_W-1:0] REC_V    = REC_W'(RECOVER_T);
  localparam logic [REC_W-1:0] REC_ONE  = REC_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] HALF_M1  = DIV_W'(TICK_HALF - 1);
  localparam logic [DIV_W-1:0] QUART_M1 = DIV_W'(TICK_HALF / 2 - 1);
  localparam logic [DIV_W-1:0] EIGHT_M1 = DIV_W'(TICK_HALF / 4 - 1);

  typedef enum logic [2:0] {
    S_WAIT  = 3'd0,
    S_LOAD  = 3'd1,
    S_DRIVE = 3'd2,
    S_COIN  = 3'd3,
    S_CRASH = 3'd4,
    S_WIN   = 3'd5,
    S_LOSE  = 3'd6,
    S_PAUSE = 3'd7
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [SW_S-1:0]  r_score, w_score_nxt, w_score_inc;
  logic [SW_L-1:0]  r_lives, w_lives_nxt;
  logic [REC_W-1:0] r_rec, w_rec_nxt;

  logic [DIV_W-1:0] r_div, w_div_nxt, w_period_m1;
  logic [2:0]       r_sw_q;
  logic             w_sw_valid, w_sw_changed, w_freeze, w_tick;

  // Divider: free-running on CLOCK_50; restarts whenever the speed select changes.
  always_comb begin
    w_sw_valid  = 1'b1;
    w_period_m1 = '0;
    case (bus.SW)
      3'b100:  w_period_m1 = HALF_M1;
      3'b010:  w_period_m1 = QUART_M1;
      3'b001:  w_period_m1 = EIGHT_M1;
      default: w_sw_valid  = 1'b0;
    endcase
  end

`ifdef GAME_PAUSE_EN
  assign w_freeze = (r_state == S_PAUSE);
`else
  assign w_freeze = 1'b0;
`endif

  assign w_sw_changed = (bus.SW != r_sw_q);
  assign w_tick = !Reset && w_sw_valid && !w_sw_changed && !w_freeze && (r_div == w_period_m1);

  always_comb begin
    w_div_nxt = r_div + DIV_ONE;
    if (!w_sw_valid || w_sw_changed) w_div_nxt = '0;
    else if (w_freeze)               w_div_nxt = r_div;
    else if (w_tick)                 w_div_nxt = '0;
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_div  <= '0;
      r_sw_q <= '0;
    end else begin
      r_div  <= w_div_nxt;
      r_sw_q <= bus.SW;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_state <= S_WAIT;
      r_score <= '0;
      r_lives <= LIVES_V;
      r_rec   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_score <= w_score_nxt;
      r_lives <= w_lives_nxt;
      r_rec   <= w_rec_nxt;
    end
  end

  assign w_score_inc = (r_score == TARGET_V) ? r_score : r_score + SC_ONE;

  always_comb begin
    w_state_nxt = r_state;
    w_score_nxt = r_score;
    w_lives_nxt = r_lives;
    w_rec_nxt   = r_rec;
    case (r_state)
      S_WAIT: begin
        if (bus.EnterEn) begin
          w_state_nxt = S_LOAD;
          w_score_nxt = '0;
          w_lives_nxt = LIVES_V;
        end
      end
      S_LOAD: if (bus.LoadDone) w_state_nxt = S_DRIVE;
      S_DRIVE: begin
        // Police takes priority; a coin in the same cycle is dropped.
        if (bus.PoliceHit) begin
          w_lives_nxt = (r_lives != '0) ? r_lives - LV_ONE : '0;
          if (r_lives <= LV_ONE) begin
            w_state_nxt = S_LOSE;
          end else begin
            w_state_nxt = S_CRASH;
            w_rec_nxt   = REC_V;
          end
`ifdef GAME_PAUSE_EN
        end else if (bus.Pause) begin
          w_state_nxt = S_PAUSE;
`endif
        end else if (bus.CoinHit) begin
          w_state_nxt = S_COIN;
        end
      end
      S_COIN: begin
        w_score_nxt = w_score_inc;
        w_state_nxt = (w_score_inc == TARGET_V) ? S_WIN : S_DRIVE;
      end
      S_CRASH: begin
        if (w_tick) begin
          if (r_rec <= REC_ONE) begin
            w_rec_nxt   = '0;
            w_state_nxt = S_DRIVE;
          end else begin
            w_rec_nxt = r_rec - REC_ONE;
          end
        end
      end
      S_WIN, S_LOSE: if (bus.EnterEn) w_state_nxt = S_WAIT;
`ifdef GAME_PAUSE_EN
      S_PAUSE: if (bus.Pause) w_state_nxt = S_DRIVE;
`endif
      default: w_state_nxt = S_WAIT;
    endcase
  end

  assign bus.SpeedTick   = w_tick;
  assign bus.DriveEn     = (r_state == S_LOAD) || (r_state == S_DRIVE);
  assign bus.Score       = r_score;
  assign bus.LivesLeft   = r_lives;
  assign bus.CrashFlash  = (r_state == S_CRASH);
  assign bus.win_screen  = (r_state == S_WIN);
  assign bus.lose_screen = (r_state == S_LOSE);
  assign bus.State       = r_state;
endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl with COIN_TARGET=3, LIVES=2, TICK_HALF=8, RECOVER_T=2.
// Inputs change 1 ns after the rising edge; outputs are sampled at that same point.
module tb_game_state_ctrl;
  logic CLOCK_50 = 1'b0;
  logic Reset;
  int   checks   = 0;
  int   failures = 0;

  game_state_ctrl_if #(.COIN_TARGET(3), .LIVES(2)) bus ();

  game_state_ctrl #(
    .COIN_TARGET(3), .LIVES(2), .TICK_HALF(8), .RECOVER_T(2)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic next_cyc();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic pulse_enter();
    bus.EnterEn = 1'b1; next_cyc(); bus.EnterEn = 1'b0;
  endtask

  task automatic pulse_load();
    bus.LoadDone = 1'b1; next_cyc(); bus.LoadDone = 1'b0;
  endtask

  task automatic pulse_coin();
    bus.CoinHit = 1'b1; next_cyc(); bus.CoinHit = 1'b0;
  endtask

  task automatic pulse_police();
    bus.PoliceHit = 1'b1; next_cyc(); bus.PoliceHit = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    next_cyc();
    next_cyc();
    checks++; if (bus.State !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.State); end
    checks++; if (bus.Score !== 2'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", bus.Score); end
    checks++; if (bus.LivesLeft !== 2'd2) begin failures++; $display("FAIL reset_lives got=%0d exp=2", bus.LivesLeft); end
    checks++; if (bus.DriveEn !== 1'b0) begin failures++; $display("FAIL reset_driveen got=%0b exp=0", bus.DriveEn); end
    checks++; if (bus.SpeedTick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%0b exp=0", bus.SpeedTick); end
    Reset = 1'b0;
  endtask

  task automatic test_divider();
    int last;
    int nt;
    last = -1; nt = 0;
    bus.SW = 3'b010;
    for (int i = 0; i < 24; i++) begin
      next_cyc();
      if (bus.SpeedTick === 1'b1) begin
        if (last >= 0) begin
          checks++; if (i - last !== 4) begin failures++; $display("FAIL tick_quarter_interval got=%0d exp=4", i - last); end
        end
        last = i; nt++;
      end
    end
    checks++; if (nt < 5) begin failures++; $display("FAIL tick_quarter_count got=%0d exp>=5", nt); end

    bus.SW = 3'b011; nt = 0;
    for (int i = 0; i < 12; i++) begin
      next_cyc();
      if (bus.SpeedTick === 1'b1) nt++;
    end
    checks++; if (nt !== 0) begin failures++; $display("FAIL tick_invalid_sw got=%0d exp=0", nt); end

    bus.SW = 3'b001; nt = 0; last = -1;
    for (int i = 0; i < 12; i++) begin
      next_cyc();
      if (bus.SpeedTick === 1'b1) begin
        if (last >= 0) begin
          checks++; if (i - last !== 2) begin failures++; $display("FAIL tick_eighth_interval got=%0d exp=2", i - last); end
        end else begin
          checks++; if (i !== 1) begin failures++; $display("FAIL tick_eighth_restart got=%0d exp=1", i); end
        end
        last = i; nt++;
      end
    end
    checks++; if (nt < 5) begin failures++; $display("FAIL tick_eighth_count got=%0d exp>=5", nt); end
  endtask

  task automatic test_win();
    pulse_enter();
    checks++; if (bus.State !== 3'd1) begin failures++; $display("FAIL win_load_state got=%0d exp=1", bus.State); end
    checks++; if (bus.DriveEn !== 1'b1) begin failures++; $display("FAIL win_load_driveen got=%0b exp=1", bus.DriveEn); end
    pulse_load();
    checks++; if (bus.State !== 3'd2) begin failures++; $display("FAIL win_drive_state got=%0d exp=2", bus.State); end
    for (int k = 1; k <= 3; k++) begin
      pulse_coin();
      checks++; if (bus.State !== 3'd3) begin failures++; $display("FAIL win_coin_state k=%0d got=%0d exp=3", k, bus.State); end
      next_cyc();
      checks++; if (bus.Score !== 2'(k)) begin failures++; $display("FAIL win_score k=%0d got=%0d exp=%0d", k, bus.Score, k); end
      next_cyc();
    end
    checks++; if (bus.State !== 3'd5) begin failures++; $display("FAIL win_state got=%0d exp=5", bus.State); end
    checks++; if (bus.win_screen !== 1'b1) begin failures++; $display("FAIL win_screen got=%0b exp=1", bus.win_screen); end
    checks++; if (bus.DriveEn !== 1'b0) begin failures++; $display("FAIL win_driveen got=%0b exp=0", bus.DriveEn); end
    pulse_enter();
    checks++; if (bus.State !== 3'd0) begin failures++; $display("FAIL win_exit_state got=%0d exp=0", bus.State); end
  endtask

  task automatic test_crash();
    int nt;
    int n;
    pulse_enter();
    checks++; if (bus.Score !== 2'd0) begin failures++; $display("FAIL crash_reload_score got=%0d exp=0", bus.Score); end
    pulse_load();
    pulse_police();
    checks++; if (bus.State !== 3'd4) begin failures++; $display("FAIL crash_state got=%0d exp=4", bus.State); end
    checks++; if (bus.LivesLeft !== 2'd1) begin failures++; $display("FAIL crash_lives got=%0d exp=1", bus.LivesLeft); end
    checks++; if (bus.CrashFlash !== 1'b1) begin failures++; $display("FAIL crash_flash got=%0b exp=1", bus.CrashFlash); end
    nt = (bus.SpeedTick === 1'b1) ? 1 : 0;
    pulse_police();
    checks++; if (bus.LivesLeft !== 2'd1) begin failures++; $display("FAIL crash_invincible_lives got=%0d exp=1", bus.LivesLeft); end
    checks++; if (bus.State !== 3'd4) begin failures++; $display("FAIL crash_invincible_state got=%0d exp=4", bus.State); end
    if (bus.State === 3'd4 && bus.SpeedTick === 1'b1) nt++;
    n = 0;
    while (bus.State !== 3'd2 && n < 20) begin
      next_cyc(); n++;
      if (bus.State === 3'd4 && bus.SpeedTick === 1'b1) nt++;
    end
    checks++; if (bus.State !== 3'd2) begin failures++; $display("FAIL crash_recover_timeout state=%0d exp=2", bus.State); end
    checks++; if (nt !== 2) begin failures++; $display("FAIL crash_recover_ticks got=%0d exp=2", nt); end
  endtask

  task automatic test_lose();
    pulse_coin();
    next_cyc();
    checks++; if (bus.Score !== 2'd1) begin failures++; $display("FAIL lose_pre_score got=%0d exp=1", bus.Score); end
    bus.CoinHit = 1'b1; bus.PoliceHit = 1'b1;
    next_cyc();
    bus.CoinHit = 1'b0; bus.PoliceHit = 1'b0;
    checks++; if (bus.State !== 3'd6) begin failures++; $display("FAIL lose_state got=%0d exp=6", bus.State); end
    checks++; if (bus.lose_screen !== 1'b1) begin failures++; $display("FAIL lose_screen got=%0b exp=1", bus.lose_screen); end
    checks++; if (bus.Score !== 2'd1) begin failures++; $display("FAIL lose_score got=%0d exp=1", bus.Score); end
    pulse_coin();
    next_cyc();
    checks++; if (bus.Score !== 2'd1 || bus.State !== 3'd6) begin failures++; $display("FAIL lose_frozen score=%0d state=%0d exp=1,6", bus.Score, bus.State); end
    pulse_enter();
    checks++; if (bus.State !== 3'd0) begin failures++; $display("FAIL lose_exit_state got=%0d exp=0", bus.State); end
  endtask

  task automatic test_pause();
    int nt;
    pulse_enter();
    pulse_load();
    bus.Pause = 1'b1; next_cyc(); bus.Pause = 1'b0;
`ifdef GAME_PAUSE_EN
    checks++; if (bus.State !== 3'd7) begin failures++; $display("FAIL pause_state got=%0d exp=7", bus.State); end
    checks++; if (bus.DriveEn !== 1'b0) begin failures++; $display("FAIL pause_driveen got=%0b exp=0", bus.DriveEn); end
    nt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.SpeedTick === 1'b1) nt++;
      next_cyc();
    end
    checks++; if (nt !== 0) begin failures++; $display("FAIL pause_ticks got=%0d exp=0", nt); end
    bus.Pause = 1'b1; next_cyc(); bus.Pause = 1'b0;
    checks++; if (bus.State !== 3'd2) begin failures++; $display("FAIL pause_resume got=%0d exp=2", bus.State); end
`else
    nt = 0;
    checks++; if (bus.State !== 3'd2) begin failures++; $display("FAIL pause_ignored_state got=%0d exp=2", bus.State); end
    checks++; if (bus.DriveEn !== 1'b1) begin failures++; $display("FAIL pause_ignored_driveen got=%0b exp=1", bus.DriveEn); end
    checks++; if (nt !== 0) begin failures++; $display("FAIL pause_ignored_ticks got=%0d exp=0", nt); end
`endif
  endtask

  task automatic test_reset_mid_crash();
    pulse_police();
    checks++; if (bus.State !== 3'd4) begin failures++; $display("FAIL rmc_crash_state got=%0d exp=4", bus.State); end
    Reset = 1'b1;
    next_cyc();
    Reset = 1'b0;
    checks++; if (bus.State !== 3'd0) begin failures++; $display("FAIL rmc_state got=%0d exp=0", bus.State); end
    checks++; if (bus.LivesLeft !== 2'd2) begin failures++; $display("FAIL rmc_lives got=%0d exp=2", bus.LivesLeft); end
    checks++; if (bus.CrashFlash !== 1'b0) begin failures++; $display("FAIL rmc_flash got=%0b exp=0", bus.CrashFlash); end
    pulse_coin();
    next_cyc();
    checks++; if (bus.State !== 3'd0 || bus.Score !== 2'd0) begin failures++; $display("FAIL wait_hit_ignored state=%0d score=%0d exp=0,0", bus.State, bus.Score); end
  endtask

  initial begin
    Reset = 1'b1;
    bus.SW = 3'b010;
    bus.EnterEn = 1'b0; bus.LoadDone = 1'b0; bus.CoinHit = 1'b0;
    bus.PoliceHit = 1'b0; bus.Pause = 1'b0;
    test_reset();
    test_divider();
    test_win();
    test_crash();
    test_lose();
    test_pause();
    test_reset_mid_crash();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
